micro_sequencer: RTL

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/useq_pkg.sv | 56 +++++
 rtl/micro_rom.sv | 67 ++++++
 rtl/micro_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared encodings and microword layout for the micro-sequencer and its ROM.
// Layout, MSB to LSB: {next, seq, csel, inv, isel, ctrl}.
package useq_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_DISPATCH = 3'd1,
        SEQ_BRANCH   = 3'd2,
        SEQ_CALL     = 3'd3,
        SEQ_RET      = 3'd4,
        SEQ_PAUSE    = 3'd5,
        SEQ_HALT     = 3'd6,
        SEQ_RSVD     = 3'd7
    } seq_e;

    typedef enum logic [1:0] {
        ISEL_ZERO = 2'd0,
        ISEL_U3   = 2'd1,
        ISEL_U7   = 2'd2,
        ISEL_S7   = 2'd3
    } isel_e;

    localparam int FETCH_ADDR = 0;
    localparam int SEQ_W      = 3;
    localparam int ISEL_W     = 2;
    localparam int OFF_CTRL   = 0;

    function automatic int csel_w(input int ncond);
        return $clog2(ncond);
    endfunction

    function automatic int off_isel(input int ctrl_w);
        return ctrl_w;
    endfunction

    function automatic int off_inv(input int ctrl_w);
        return ctrl_w + ISEL_W;
    endfunction

    function automatic int off_csel(input int ctrl_w);
        return ctrl_w + ISEL_W + 1;
    endfunction

    function automatic int off_seq(input int ctrl_w, input int cs_w);
        return ctrl_w + ISEL_W + 1 + cs_w;
    endfunction

    function automatic int off_next(input int ctrl_w, input int cs_w);
        return ctrl_w + ISEL_W + 1 + cs_w + SEQ_W;
    endfunction

    function automatic int word_w(input int ua_w, input int cs_w, input int ctrl_w);
        return ua_w + SEQ_W + cs_w + 1 + ISEL_W + ctrl_w;
    endfunction

endpackage

// File: rtl/micro_rom.sv
// Combinational microcode table; addresses not listed hold a NEXT->FETCH word.
module micro_rom
    import useq_pkg::*;
#(
    parameter int UA_W   = 10,
    parameter int CTRL_W = 34,
    parameter int CSEL_W = 2,
    parameter int WORD_W = word_w(UA_W, CSEL_W, CTRL_W)
) (
    input  logic [UA_W-1:0]   i_addr,
    output logic [WORD_W-1:0] o_word
);

    localparam int OFF_ISEL = off_isel(CTRL_W);
    localparam int OFF_INV  = off_inv(CTRL_W);
    localparam int OFF_CSEL = off_csel(CTRL_W);
    localparam int OFF_SEQ  = off_seq(CTRL_W, CSEL_W);
    localparam int OFF_NEXT = off_next(CTRL_W, CSEL_W);

    function automatic logic [WORD_W-1:0] uw(input logic [11:0] nxt, input seq_e seq,
                                             input int csel, input logic inv,
                                             input isel_e isel, input logic [33:0] ctrl);
        logic [WORD_W-1:0] w;
        w = '0;
        w[OFF_NEXT +: UA_W]     = UA_W'(nxt);
        w[OFF_SEQ +: SEQ_W]     = seq;
        w[OFF_CSEL +: CSEL_W]   = CSEL_W'(csel);
        w[OFF_INV]              = inv;
        w[OFF_ISEL +: ISEL_W]   = isel;
        w[OFF_CTRL +: CTRL_W]   = CTRL_W'(ctrl);
        return w;
    endfunction

    always_comb begin
        o_word = '0;
        case (i_addr)
            UA_W'(12'h000): o_word = uw(12'h001, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0001);
            UA_W'(12'h001): o_word = uw(12'h000, SEQ_DISPATCH, 0, 1'b0, ISEL_U3,   34'h0_0000_0002);
            UA_W'(12'h010): o_word = uw(12'h020, SEQ_BRANCH,   1, 1'b0, ISEL_U7,   34'h1_0000_0010);
            UA_W'(12'h011): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0011);
            UA_W'(12'h018): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_S7,   34'h3_FFFF_0018);
            UA_W'(12'h020): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0020);
            UA_W'(12'h030): o_word = uw(12'h031, SEQ_RSVD,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0030);
            UA_W'(12'h031): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_U7,   34'h0_0000_0031);
            UA_W'(12'h040): o_word = uw(12'h050, SEQ_CALL,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0040);
            UA_W'(12'h041): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0041);
            UA_W'(12'h050): o_word = uw(12'h000, SEQ_RET,      0, 1'b0, ISEL_ZERO, 34'h0_0000_0050);
            UA_W'(12'h060): o_word = uw(12'h070, SEQ_BRANCH,   0, 1'b1, ISEL_ZERO, 34'h2_0000_0060);
            UA_W'(12'h061): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0061);
            UA_W'(12'h070): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0070);
            UA_W'(12'h080): o_word = uw(12'h090, SEQ_CALL,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0080);
            UA_W'(12'h081): o_word = uw(12'h000, SEQ_RET,      0, 1'b0, ISEL_ZERO, 34'h0_0000_0081);
            UA_W'(12'h090): o_word = uw(12'h0A0, SEQ_CALL,     0, 1'b0, ISEL_ZERO, 34'h0_0000_0090);
            UA_W'(12'h091): o_word = uw(12'h000, SEQ_RET,      0, 1'b0, ISEL_ZERO, 34'h0_0000_0091);
            UA_W'(12'h0A0): o_word = uw(12'h0B0, SEQ_CALL,     0, 1'b0, ISEL_ZERO, 34'h0_0000_00A0);
            UA_W'(12'h0B0): o_word = uw(12'h000, SEQ_RET,      0, 1'b0, ISEL_ZERO, 34'h0_0000_00B0);
            UA_W'(12'h0C0): o_word = uw(12'h000, SEQ_HALT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_00C0);
            UA_W'(12'h0D0): o_word = uw(12'h3FF, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_00D0);
            UA_W'(12'h0F8): o_word = uw(12'h0F9, SEQ_PAUSE,    0, 1'b0, ISEL_S7,   34'h0_0000_00F8);
            UA_W'(12'h0F9): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_00F9);
            UA_W'(12'h3FE): o_word = uw(12'h000, SEQ_NEXT,     0, 1'b0, ISEL_ZERO, 34'h0_0000_03FE);
            UA_W'(12'h3FF): o_word = uw(12'h3FE, SEQ_BRANCH,   0, 1'b0, ISEL_ZERO, 34'h0_0000_03FF);
            default:        o_word = '0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: upc register, micro-call stack and sticky stack-error flag.
// Control field and immediate are decoded combinationally from the microword at upc.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int IR_W   = 16,
    parameter int UA_W   = 10,
    parameter int CTRL_W = 34,
    parameter int NCOND  = 4,
    parameter int STK_D  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [IR_W-1:0]   ir,
    input  logic [NCOND-1:0]  cond,
    input  logic              resume,
    output logic [CTRL_W-1:0] ctrl,
    output logic [IR_W-1:0]   immediate,
    output logic [UA_W-1:0]   upc,
    output logic              fetch_led,
    output logic              pause_led,
    output logic              uerr
);

    localparam int CSEL_W   = csel_w(NCOND);
    localparam int WORD_W   = word_w(UA_W, CSEL_W, CTRL_W);
    localparam int OFF_ISEL = off_isel(CTRL_W);
    localparam int OFF_INV  = off_inv(CTRL_W);
    localparam int OFF_CSEL = off_csel(CTRL_W);
    localparam int OFF_SEQ  = off_seq(CTRL_W, CSEL_W);
    localparam int OFF_NEXT = off_next(CTRL_W, CSEL_W);
    localparam int SP_W     = $clog2(STK_D + 1);
    localparam int IDX_W    = (STK_D > 1) ? $clog2(STK_D) : 1;

    logic [WORD_W-1:0] w_word;
    logic [UA_W-1:0]   r_upc;
    logic [UA_W-1:0]   r_stk [STK_D];
    logic [SP_W-1:0]   r_sp;
    logic              r_uerr;
    logic [UA_W-1:0]   w_next;
    logic [UA_W-1:0]   w_upc_inc;
    logic [UA_W-1:0]   w_dispatch;
    seq_e              w_seq;
    isel_e             w_isel;
    logic [CSEL_W-1:0] w_csel;
    logic              w_inv;
    logic              w_taken;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_pop_idx;
    logic              w_unused_ir;

    micro_rom #(
        .UA_W   (UA_W),
        .CTRL_W (CTRL_W),
        .CSEL_W (CSEL_W),
        .WORD_W (WORD_W)
    ) u_rom (
        .i_addr (r_upc),
        .o_word (w_word)
    );

    assign w_next     = w_word[OFF_NEXT +: UA_W];
    assign w_seq      = seq_e'(w_word[OFF_SEQ +: SEQ_W]);
    assign w_csel     = w_word[OFF_CSEL +: CSEL_W];
    assign w_inv      = w_word[OFF_INV];
    assign w_isel     = isel_e'(w_word[OFF_ISEL +: ISEL_W]);
    assign ctrl       = w_word[OFF_CTRL +: CTRL_W];

    assign w_upc_inc  = r_upc + UA_W'(1);
    assign w_dispatch = UA_W'({ir[IR_W-1 -: 5], 3'b000});
    assign w_taken    = cond[w_csel] ^ w_inv;
    assign w_full     = (r_sp == SP_W'(STK_D));
    assign w_empty    = (r_sp == '0);
    assign w_push     = en && (w_seq == SEQ_CALL) && !w_full;
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_unused_ir = ^ir;

    always_comb begin
        immediate = '0;
        case (w_isel)
            ISEL_U3: immediate = IR_W'(ir[2:0]);
            ISEL_U7: immediate = IR_W'(ir[6:0]);
            ISEL_S7: immediate = {{(IR_W-7){ir[6]}}, ir[6:0]};
            default: immediate = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upc  <= UA_W'(FETCH_ADDR);
            r_sp   <= '0;
            r_uerr <= 1'b0;
        end else if (en) begin
            case (w_seq)
                SEQ_DISPATCH: r_upc <= w_dispatch;
                SEQ_BRANCH:   r_upc <= w_taken ? w_next : w_upc_inc;
                SEQ_CALL: begin
                    // A call into a full stack still jumps; only the return link is lost.
                    r_upc <= w_next;
                    if (w_full) r_uerr <= 1'b1;
                    else        r_sp   <= r_sp + SP_W'(1);
                end
                SEQ_RET: begin
                    if (w_empty) begin
                        r_uerr <= 1'b1;
                        r_upc  <= UA_W'(FETCH_ADDR);
                    end else begin
                        r_upc <= r_stk[w_pop_idx];
                        r_sp  <= r_sp - SP_W'(1);
                    end
                end
                SEQ_PAUSE:    if (resume) r_upc <= w_next;
                SEQ_HALT:     r_upc <= r_upc;
                default:      r_upc <= w_next;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_stk[w_push_idx] <= w_upc_inc;
    end

    assign upc       = r_upc;
    assign uerr      = r_uerr;
    assign fetch_led = (r_upc == UA_W'(FETCH_ADDR));
    assign pause_led = (w_seq == SEQ_PAUSE) && !resume;

endmodule
